// File: rtl/matrix_pkg.sv
// Shared types and RAM word layout for the HUB75 scan controller.
package matrix_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_SHIFT_LO = 3'd2,
        S_SHIFT_HI = 3'd3,
        S_BLANK    = 3'd4,
        S_LATCH    = 3'd5,
        S_DISPLAY  = 3'd6
    } state_t;

    localparam int BITS_PER_PLANE = 6;
    localparam int OFS_R0 = 5;
    localparam int OFS_G0 = 4;
    localparam int OFS_B0 = 3;
    localparam int OFS_R1 = 2;
    localparam int OFS_G1 = 1;
    localparam int OFS_B1 = 0;

endpackage

// File: rtl/matrix_bcm_timer.sv
// Loadable down-counter timing the DISPLAY phase of one bit plane.
module matrix_bcm_timer #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_dec,
    input  logic [CNT_W-1:0] i_val,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (i_dec && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // done on the last display cycle so the FSM leaves after exactly i_val cycles
    assign o_done = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/matrix_scan_ctrl.sv
// HUB75 scan scheduler: row-pair / bit-plane / column sequencing over a double-buffered frame RAM.
module matrix_scan_ctrl
    import matrix_pkg::*;
#(
    parameter int COLS       = 32,
    parameter int ROW_ADDR_W = 4,
    parameter int PLANES     = 4,
    parameter int BASE_ON    = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   en,
    input  logic                                   swap_req,
    output logic                                   swap_ack,
    output logic                                   disp_buf,
    output logic [ROW_ADDR_W+$clog2(COLS):0]       rd_addr,
    input  logic [BITS_PER_PLANE*PLANES-1:0]       rd_data,
    output logic                                   R0,
    output logic                                   G0,
    output logic                                   B0,
    output logic                                   R1,
    output logic                                   G1,
    output logic                                   B1,
    output logic                                   outclk,
    output logic                                   latch,
    output logic                                   eo,
    output logic [ROW_ADDR_W-1:0]                  row_address,
    output logic                                   frame_done
);

    localparam int COL_W = $clog2(COLS);
    localparam int PL_W  = $clog2(PLANES);
    localparam int CNT_W = $clog2(BASE_ON << (PLANES - 1)) + 1;

    state_t r_state;
    state_t w_state_nxt;

    logic [COL_W-1:0]          r_col;
    logic [PL_W-1:0]           r_plane;
    logic [ROW_ADDR_W-1:0]     r_row;
    logic [ROW_ADDR_W-1:0]     r_row_address;
    logic [BITS_PER_PLANE-1:0] r_rgb;
    logic                      r_disp_buf;
    logic                      r_outclk;
    logic                      r_latch;
    logic                      r_eo;
    logic                      r_swap_ack;
    logic                      r_frame_done;

    logic                      w_last_col;
    logic                      w_last_plane;
    logic                      w_last_row;
    logic                      w_disp_done;
    logic                      w_line_end;
    logic                      w_frame_end;
    logic                      w_outclk_nxt;
    logic                      w_latch_nxt;
    logic                      w_eo_nxt;
    logic [CNT_W-1:0]          w_on_cycles;

    assign w_last_col   = (r_col == COL_W'(COLS - 1));
    assign w_last_plane = (r_plane == PL_W'(PLANES - 1));
    assign w_last_row   = &r_row;
    assign w_line_end   = (r_state == S_DISPLAY) && w_disp_done;
    assign w_frame_end  = w_line_end && w_last_plane && w_last_row;
    assign w_on_cycles  = CNT_W'(BASE_ON) << r_plane;

    matrix_bcm_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .i_load (r_state == S_LATCH),
        .i_dec  (r_state == S_DISPLAY),
        .i_val  (w_on_cycles),
        .o_done (w_disp_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:     if (en) w_state_nxt = S_FETCH;
            S_FETCH:    w_state_nxt = S_SHIFT_LO;
            S_SHIFT_LO: w_state_nxt = S_SHIFT_HI;
            S_SHIFT_HI: w_state_nxt = w_last_col ? S_BLANK : S_FETCH;
            S_BLANK:    w_state_nxt = S_LATCH;
            S_LATCH:    w_state_nxt = S_DISPLAY;
            S_DISPLAY: begin
                // en is only sampled at frame end so a frame is never cut short
                if (w_disp_done) begin
                    w_state_nxt = (w_frame_end && !en) ? S_IDLE : S_FETCH;
                end
            end
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // panel strobes are registered from the next state so they line up with it
    always_comb begin
        w_outclk_nxt = 1'b0;
        w_latch_nxt  = 1'b0;
        w_eo_nxt     = 1'b0;
        unique case (w_state_nxt)
            S_IDLE:     w_eo_nxt = 1'b1;
            S_SHIFT_HI: w_outclk_nxt = 1'b1;
            S_BLANK:    w_eo_nxt = 1'b1;
            S_LATCH: begin
                w_eo_nxt    = 1'b1;
                w_latch_nxt = 1'b1;
            end
            default: begin
                w_eo_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outclk <= 1'b0;
            r_latch  <= 1'b0;
            r_eo     <= 1'b1;
        end else begin
            r_outclk <= w_outclk_nxt;
            r_latch  <= w_latch_nxt;
            r_eo     <= w_eo_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col         <= '0;
            r_plane       <= '0;
            r_row         <= '0;
            r_row_address <= '0;
            r_rgb         <= '0;
            r_disp_buf    <= 1'b0;
            r_swap_ack    <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_swap_ack   <= 1'b0;
            r_frame_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_col   <= '0;
                    r_plane <= '0;
                    r_row   <= '0;
                end
                S_SHIFT_LO: begin
                    r_rgb <= rd_data[int'(r_plane)*BITS_PER_PLANE +: BITS_PER_PLANE];
                end
                S_SHIFT_HI: begin
                    r_col <= w_last_col ? '0 : r_col + 1'b1;
                end
                S_BLANK: begin
                    r_row_address <= r_row;
                end
                S_DISPLAY: begin
                    if (w_line_end) begin
                        r_plane <= w_last_plane ? '0 : r_plane + 1'b1;
                        if (w_last_plane) r_row <= r_row + 1'b1;
                    end
                    // buffers only change hands between frames
                    if (w_frame_end) begin
                        r_frame_done <= 1'b1;
                        if (swap_req) begin
                            r_disp_buf <= ~r_disp_buf;
                            r_swap_ack <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_col <= r_col;
                end
            endcase
        end
    end

    assign rd_addr     = {r_disp_buf, r_row, r_col};
    assign disp_buf    = r_disp_buf;
    assign swap_ack    = r_swap_ack;
    assign frame_done  = r_frame_done;
    assign row_address = r_row_address;
    assign outclk      = r_outclk;
    assign latch       = r_latch;
    assign eo          = r_eo;
    assign R0          = r_rgb[OFS_R0];
    assign G0          = r_rgb[OFS_G0];
    assign B0          = r_rgb[OFS_B0];
    assign R1          = r_rgb[OFS_R1];
    assign G1          = r_rgb[OFS_G1];
    assign B1          = r_rgb[OFS_B1];

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Directed bench for matrix_scan_ctrl with a 1-cycle-latency frame RAM and a colour scoreboard.
module tb_matrix_scan_ctrl;

    localparam int COLS    = 32;
    localparam int RW      = 4;
    localparam int PLANES  = 4;
    localparam int BASE_ON = 8;
    localparam int FRAME   = 16 * 512;

    logic        clk;
    logic        reset;
    logic        en;
    logic        swap_req;
    logic        swap_ack;
    logic        disp_buf;
    logic [9:0]  rd_addr;
    logic [23:0] rd_data;
    logic        R0, G0, B0, R1, G1, B1;
    logic        outclk;
    logic        latch;
    logic        eo;
    logic [3:0]  row_address;
    logic        frame_done;

    matrix_scan_ctrl #(
        .COLS       (COLS),
        .ROW_ADDR_W (RW),
        .PLANES     (PLANES),
        .BASE_ON    (BASE_ON)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .disp_buf    (disp_buf),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .R0          (R0),
        .G0          (G0),
        .B0          (B0),
        .R1          (R1),
        .G1          (G1),
        .B1          (B1),
        .outclk      (outclk),
        .latch       (latch),
        .eo          (eo),
        .row_address (row_address),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [23:0] mem [1024];

    always @(posedge clk) rd_data <= mem[rd_addr];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_oclk = 0;
    logic p_eo = 1'b1;
    logic p_oclk = 1'b0;
    logic p_latch = 1'b0;
    logic [5:0] sb_q [$];

    function automatic logic [5:0] exp_rgb(int b, int r, int c, int p);
        if (b == 0) return ((c + p + r) % 2 == 0) ? 6'b100001 : 6'b000000;
        return ((c + p + r) % 2 == 0) ? 6'b010010 : 6'b001100;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic push_line(input int b, input int r, input int p, input int ncols);
        for (int c = 0; c < ncols; c++) sb_q.push_back(exp_rgb(b, r, c, p));
    endtask

    task automatic tick();
        logic [5:0] e;
        p_eo    = eo;
        p_oclk  = outclk;
        p_latch = latch;
        @(negedge clk);
        cyc++;
        if (outclk && !p_oclk) begin
            n_oclk++;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("sb_rgb", {26'd0, R0, G0, B0, R1, G1, B1}, {26'd0, e});
            end
        end
    endtask

    int cyc_en, cyc_rs, edges_first, early_ack, n0, eo_low;
    bit found;
    int eo_t [$];
    int la_t [$];
    int la_row [$];
    int per_tab [4] = '{106, 114, 130, 162};
    int on_tab  [4] = '{8, 16, 32, 64};
    int row_tab [5] = '{0, 0, 0, 0, 1};

    initial begin
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 16; r++)
                for (int c = 0; c < COLS; c++)
                    for (int p = 0; p < PLANES; p++)
                        mem[b*512 + r*32 + c][6*p +: 6] = exp_rgb(b, r, c, p);

        // reset state
        reset = 1'b1;
        en = 1'b0;
        swap_req = 1'b0;
        repeat (3) tick();
        chk("rst_eo", eo, 1);
        chk("rst_outclk", outclk, 0);
        chk("rst_latch", latch, 0);
        chk("rst_rgb", {R0, G0, B0, R1, G1, B1}, 0);
        chk("rst_ack", swap_ack, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_row", row_address, 0);
        chk("rst_addr", rd_addr, 0);
        chk("rst_buf", disp_buf, 0);

        reset = 1'b0;
        n_oclk = 0;
        repeat (5) tick();
        chk("idle_eo", eo, 1);
        chk("idle_oclk", n_oclk, 0);

        // first line colours and BCM timing of row 0 planes 0..3
        push_line(0, 0, 0, COLS);
        en = 1'b1;
        cyc_en = cyc;
        edges_first = -1;
        for (int i = 0; i < 1200 && la_t.size() < 5; i++) begin
            tick();
            if (eo && !p_eo) begin
                eo_t.push_back(cyc);
                if (edges_first < 0) edges_first = n_oclk;
            end
            if (latch && !p_latch) begin
                la_t.push_back(cyc);
                la_row.push_back(int'(row_address));
            end
        end
        chk("latch_cnt", la_t.size(), 5);
        chk("shift_edges", edges_first, 32);
        chk("sb_drain0", sb_q.size(), 0);
        if (la_t.size() == 5 && eo_t.size() == 5) begin
            chk("blank_time", eo_t[0] - cyc_en, 97);
            chk("latch_after_eo", la_t[0] - eo_t[0], 1);
            for (int i = 0; i < 5; i++) chk("latch_row", la_row[i], row_tab[i]);
            for (int i = 0; i < 4; i++) begin
                chk("line_period", la_t[i+1] - la_t[i], per_tab[i]);
                chk("display_len", eo_t[i+1] - la_t[i] - (3*COLS + 1), on_tab[i]);
            end
        end

        // swap request held mid-frame
        swap_req = 1'b1;
        found = 1'b0;
        early_ack = 0;
        for (int i = 0; i < FRAME + 100 && !found; i++) begin
            tick();
            if (frame_done) found = 1'b1;
            else if (swap_ack) early_ack++;
        end
        chk("fd_seen", found, 1);
        chk("early_ack", early_ack, 0);
        chk("fd_time", cyc - cyc_en, FRAME + 1);
        chk("ack_with_fd", swap_ack, 1);
        chk("buf_toggled", disp_buf, 1);
        chk("addr_msb", rd_addr[9], 1);
        push_line(1, 0, 0, 10);
        tick();
        chk("fd_pulse", frame_done, 0);
        chk("ack_pulse", swap_ack, 0);
        swap_req = 1'b0;
        for (int i = 0; i < 100 && sb_q.size() > 0; i++) tick();
        chk("sb_drain1", sb_q.size(), 0);
        repeat (3) tick();
        chk("col10_hi", outclk, 1);
        chk("col10_addr", rd_addr, 512 + 10);

        // asynchronous reset during SHIFT_HI of column 10
        reset = 1'b1;
        #1;
        chk("arst_oclk", outclk, 0);
        chk("arst_eo", eo, 1);
        chk("arst_addr", rd_addr, 0);
        chk("arst_buf", disp_buf, 0);
        push_line(0, 0, 0, COLS);
        tick();
        chk("arst_hold_eo", eo, 1);
        reset = 1'b0;
        tick();
        chk("restart_addr", rd_addr, 0);
        chk("restart_eo", eo, 0);
        cyc_rs = cyc;

        // en dropped at row 5: frame completes then idles
        found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            tick();
            if (row_address == 4'd5) found = 1'b1;
        end
        chk("row5_seen", found, 1);
        en = 1'b0;
        found = 1'b0;
        for (int i = 0; i < FRAME && !found; i++) begin
            tick();
            if (frame_done) found = 1'b1;
        end
        chk("fd2_seen", found, 1);
        chk("fd2_time", cyc - cyc_rs, FRAME);
        chk("fd2_eo", eo, 1);
        chk("fd2_noack", swap_ack, 0);
        chk("fd2_row", row_address, 15);
        chk("fd2_buf", disp_buf, 0);
        chk("sb_drain2", sb_q.size(), 0);
        n0 = n_oclk;
        eo_low = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!eo) eo_low++;
        end
        chk("idle_no_clk", n_oclk - n0, 0);
        chk("idle_eo_low", eo_low, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
